// File: rtl/std_reg_file_if.sv
// Register-file access bundle: one masked write port plus two read ports.
// Latency: none of its own; pure wiring between requester and register file.
// Backpressure: none; writes always accepted or rejected, result on done/err.
// Ports: write_en/write_addr/in/write_mask (write request), read_addr0/1 -> out0/1,
//        done/err (registered write outcome pulses).
interface std_reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
);
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  write_mask;
    logic [ADDR_W-1:0] read_addr0;
    logic [ADDR_W-1:0] read_addr1;
    logic [WIDTH-1:0]  out0;
    logic [WIDTH-1:0]  out1;
    logic              done;
    logic              err;

    // Requester side (control FSM / testbench).
    modport master (
        output write_en, write_addr, in, write_mask, read_addr0, read_addr1,
        input  out0, out1, done, err
    );

    // Register-file side.
    modport slave (
        input  write_en, write_addr, in, write_mask, read_addr0, read_addr1,
        output out0, out1, done, err
    );
endinterface

// File: rtl/std_reg_file.sv
// Bank of NUM_REGS x WIDTH registers, one bit-masked write port, two combinational read ports.
// Latency: write visible 1 cycle after the edge (same cycle with BYPASS=1); done/err registered, 1 cycle.
// Backpressure: none; out-of-range writes are dropped and flagged with a one-cycle err pulse.
// Ports: clk (rising edge), reset (async, active-high), bus (std_reg_file_if.slave).
module std_reg_file #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit BYPASS   = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    std_reg_file_if.slave bus
);
    // One extra bit so NUM_REGS itself is representable for the range check.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [WIDTH-1:0] mem [NUM_REGS];

    logic             in_range;
    logic             write_ok;
    logic             write_bad;
    logic [WIDTH-1:0] stored_w;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rd0;
    logic [WIDTH-1:0] rd1;
    logic             done_q;
    logic             err_q;

    assign in_range  = ({1'b0, bus.write_addr} < LIMIT);
    assign write_ok  = bus.write_en & in_range;
    assign write_bad = bus.write_en & ~in_range;

    // Address decode by comparison against every valid index: addresses past
    // NUM_REGS match nothing, so reads return 0 and no entry is ever touched.
    always_comb begin
        stored_w = '0;
        rd0      = '0;
        rd1      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.write_addr == ADDR_W'(i)) stored_w = mem[i];
            if (bus.read_addr0 == ADDR_W'(i)) rd0      = mem[i];
            if (bus.read_addr1 == ADDR_W'(i)) rd1      = mem[i];
        end
    end

    assign merged = (stored_w & ~bus.write_mask) | (bus.in & bus.write_mask);

    // Same-cycle forwarding of the merged write value when enabled.
    always_comb begin
        bus.out0 = rd0;
        bus.out1 = rd1;
        if (BYPASS && write_ok && (bus.read_addr0 == bus.write_addr)) bus.out0 = merged;
        if (BYPASS && write_ok && (bus.read_addr1 == bus.write_addr)) bus.out1 = merged;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (write_ok && (bus.write_addr == ADDR_W'(i))) mem[i] <= merged;
            end
            // A zero mask is still an accepted write and pulses done.
            done_q <= write_ok;
            err_q  <= write_bad;
        end
    end

    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_std_reg_file.sv
module tb_std_reg_file;
    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic [2:0]  write_addr;
    logic [31:0] in_d;
    logic [31:0] write_mask;
    logic [2:0]  read_addr0;
    logic [2:0]  read_addr1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // a: 8 entries, no bypass; b: 8 entries, bypass; c: 6 entries, no bypass.
    std_reg_file_if #(.WIDTH(32), .ADDR_W(3)) if_a ();
    std_reg_file_if #(.WIDTH(32), .ADDR_W(3)) if_b ();
    std_reg_file_if #(.WIDTH(32), .ADDR_W(3)) if_c ();

    std_reg_file #(.WIDTH(32), .NUM_REGS(8), .BYPASS(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    std_reg_file #(.WIDTH(32), .NUM_REGS(8), .BYPASS(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    std_reg_file #(.WIDTH(32), .NUM_REGS(6), .BYPASS(1'b0)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    assign if_a.write_en = write_en;   assign if_b.write_en = write_en;   assign if_c.write_en = write_en;
    assign if_a.write_addr = write_addr; assign if_b.write_addr = write_addr; assign if_c.write_addr = write_addr;
    assign if_a.in = in_d;             assign if_b.in = in_d;             assign if_c.in = in_d;
    assign if_a.write_mask = write_mask; assign if_b.write_mask = write_mask; assign if_c.write_mask = write_mask;
    assign if_a.read_addr0 = read_addr0; assign if_b.read_addr0 = read_addr0; assign if_c.read_addr0 = read_addr0;
    assign if_a.read_addr1 = read_addr1; assign if_b.read_addr1 = read_addr1; assign if_c.read_addr1 = read_addr1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] m);
        write_en   = 1'b1;
        write_addr = a;
        in_d       = d;
        write_mask = m;
    endtask

    task automatic idle();
        write_en   = 1'b0;
        write_addr = '0;
        in_d       = '0;
        write_mask = '0;
    endtask

    logic [31:0] exp_c [6];

    initial begin
        reset = 1'b1;
        idle();
        read_addr0 = '0;
        read_addr1 = '0;

        // Reset then read every entry on both ports.
        #2;
        for (int i = 0; i < 8; i++) begin
            read_addr0 = 3'(i);
            read_addr1 = 3'(7 - i);
            #1;
            check("rst_out0", if_a.out0, 32'h0);
            check("rst_out1", if_a.out1, 32'h0);
        end
        check("rst_done", {31'b0, if_a.done}, 32'h0);
        check("rst_err",  {31'b0, if_a.err},  32'h0);

        // Reset held high: a write edge is ignored.
        wr(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_addr0 = 3'd2;
        tick();
        check("rsthold_out0", if_a.out0, 32'h0);
        check("rsthold_done", {31'b0, if_a.done}, 32'h0);
        idle();
        reset = 1'b0;

        // Full write to entry 3.
        read_addr0 = 3'd3;
        wr(3'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        tick();
        check("full_done", {31'b0, if_a.done}, 32'h1);
        check("full_err",  {31'b0, if_a.err},  32'h0);
        check("full_out0", if_a.out0, 32'hDEAD_BEEF);
        idle();
        tick();
        check("idle_done", {31'b0, if_a.done}, 32'h0);

        // Masked write, then zero-mask write back to back.
        wr(3'd3, 32'h1234_5678, 32'h0000_FFFF);
        tick();
        check("mask_out0", if_a.out0, 32'hDEAD_5678);
        check("mask_done", {31'b0, if_a.done}, 32'h1);
        wr(3'd3, 32'hFFFF_FFFF, 32'h0000_0000);
        tick();
        check("zmask_done", {31'b0, if_a.done}, 32'h1);
        check("zmask_out0", if_a.out0, 32'hDEAD_5678);
        idle();
        tick();

        // Bypass vs no bypass on entry 5.
        read_addr1 = 3'd5;
        wr(3'd5, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
        #1;
        check("byp_b_out1",   if_b.out1, 32'hA5A5_A5A5);
        check("nobyp_a_out1", if_a.out1, 32'h0);
        check("byp_b_out0",   if_b.out0, 32'hDEAD_5678);
        tick();
        check("nobyp_a_after", if_a.out1, 32'hA5A5_A5A5);
        // Bypass of a partial-mask merge on entry 3.
        wr(3'd3, 32'h0000_0000, 32'hFFFF_0000);
        #1;
        check("byp_merge_b", if_b.out0, 32'h0000_5678);
        check("nobyp_merge_a", if_a.out0, 32'hDEAD_5678);
        tick();
        check("merge_a_after", if_a.out0, 32'h0000_5678);

        // Out-of-range write on the 6-entry bank.
        wr(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        check("oor_err_c",  {31'b0, if_c.err},  32'h1);
        check("oor_done_c", {31'b0, if_c.done}, 32'h0);
        check("inr_done_a", {31'b0, if_a.done}, 32'h1);
        check("inr_err_a",  {31'b0, if_a.err},  32'h0);
        idle();
        exp_c[0] = 32'h0; exp_c[1] = 32'h0; exp_c[2] = 32'h0;
        exp_c[3] = 32'h0000_5678; exp_c[4] = 32'h0; exp_c[5] = 32'hA5A5_A5A5;
        for (int i = 0; i < 6; i++) begin
            read_addr0 = 3'(i);
            #1;
            check("oor_keep_c", if_c.out0, exp_c[i]);
        end
        read_addr0 = 3'd6;
        read_addr1 = 3'd7;
        #1;
        check("oor_read6_c", if_c.out0, 32'h0);
        check("oor_read7_c", if_c.out1, 32'h0);
        check("read7_a",     if_a.out1, 32'hFFFF_FFFF);
        tick();
        check("oor_err_clr", {31'b0, if_c.err}, 32'h0);

        // Async reset mid-stream during back-to-back writes.
        read_addr0 = 3'd0;
        read_addr1 = 3'd1;
        wr(3'd0, 32'h1111_1111, 32'hFFFF_FFFF);
        tick();
        check("b2b_done0", {31'b0, if_a.done}, 32'h1);
        wr(3'd1, 32'h2222_2222, 32'hFFFF_FFFF);
        tick();
        check("b2b_done1", {31'b0, if_a.done}, 32'h1);
        check("b2b_out0",  if_a.out0, 32'h1111_1111);
        check("b2b_out1",  if_a.out1, 32'h2222_2222);
        wr(3'd2, 32'h3333_3333, 32'hFFFF_FFFF);
        #2;
        reset = 1'b1;
        #1;
        check("arst_done", {31'b0, if_a.done}, 32'h0);
        check("arst_out0", if_a.out0, 32'h0);
        check("arst_out1", if_a.out1, 32'h0);
        read_addr0 = 3'd3;
        read_addr1 = 3'd5;
        #1;
        check("arst_e3", if_a.out0, 32'h0);
        check("arst_e5", if_a.out1, 32'h0);
        tick();
        idle();
        reset = 1'b0;
        read_addr0 = 3'd2;
        #1;
        check("arst_lost_e2", if_a.out0, 32'h0);
        check("arst_done2",   {31'b0, if_a.done}, 32'h0);

        // First write after reset release behaves normally.
        wr(3'd2, 32'h3333_3333, 32'hFFFF_FFFF);
        tick();
        check("post_rst_done", {31'b0, if_a.done}, 32'h1);
        check("post_rst_out0", if_a.out0, 32'h3333_3333);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/std_reg_file.md
# std_reg_file

Parametrised multi-entry successor to the single-word `std_reg`: a bank of `NUM_REGS` registers, each `WIDTH` bits wide, with one masked write port and two independent read ports. It keeps the single-register write/`done` contract, so control FSMs can use the one-cycle `done` pulse as their group-completion signal. It sits in the same primitive library, for generated designs that need indexed storage without instantiating many separate registers.

## Interface
- `WIDTH`, 32, data width of each entry (≥1)
- `NUM_REGS`, 8, number of entries (≥2, need not be a power of two)
- `ADDR_W`, `$clog2(NUM_REGS)`, address width (derived; do not override)
- `BYPASS`, 0, 1 = a read of the entry being written this cycle returns the merged new value; 0 = it returns the old value
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately on assertion
- `write_en`  in  1  write request, sampled at the `clk` rising edge
- `write_addr`  in  ADDR_W  target entry
- `in`  in  WIDTH  write data
- `write_mask`  in  WIDTH  per-bit enable; only bits at 1 are updated
- `read_addr0`, `read_addr1`  in  ADDR_W  read addresses
- `out0`, `out1`  out  WIDTH  read data
- `done`  out  1  one-cycle pulse following an accepted write
- `err`  out  1  one-cycle pulse following a rejected (out-of-range) write

## Operation
- Storage: `NUM_REGS` × `WIDTH` flops. `reset` clears every entry to 0, and `done` and `err` to 0, asynchronously. Reset does not depend on `clk`.
- Write: at a rising edge with `write_en`=1 and `write_addr` < `NUM_REGS`:
  - `mem[write_addr]` ← `(mem & ~write_mask) | (in & write_mask)`.
  - `done` is 1 for the next cycle and `err` is 0.
- Rejected write: `write_en`=1 and `write_addr` ≥ `NUM_REGS` (possible only when `NUM_REGS` is not a power of two).
  - No entry changes.
  - `done`=0 and `err`=1 for the next cycle.
- Idle: `write_en`=0 at an edge → `done`=0, `err`=0 next cycle. A mask of all zeros still counts as an accepted write: `done` pulses and the data is unchanged.
- Reads: combinational from `read_addrN`. An out-of-range read address returns 0. Both ports may address the same entry, or the write entry, in the same cycle.
- `BYPASS`=1: when `write_en`=1 and `read_addrN`==`write_addr` (in range), `outN` shows the merged value that will be written, in the same cycle. `BYPASS`=0: `outN` shows the stored value and updates after the edge.
- Back-to-back writes are allowed every cycle, to the same or different entries. `done` then stays high for consecutive cycles, one cycle per accepted write.

## Timing
- Write latency: 1 cycle. New data is visible on the read ports from the cycle after the write edge, or in the same cycle when `BYPASS`=1.
- `done` and `err` are registered: they are asserted during the cycle after the sampling edge and are mutually exclusive.
- Read path: pure combinational mux from `read_addrN` and storage (plus the bypass merge). There is no read enable and no read latency.
- Reset asserted mid-write: the write is lost. All entries, `done` and `err` go to 0 without waiting for a clock edge. The first write edge after `reset` deasserts behaves normally.
- Reset held high: edges are ignored and all outputs hold their reset values: `out0`=`out1`=0, `done`=0, `err`=0.

## Test plan
- Reset then read: assert `reset`, read all 8 entries on both ports → all 0, `done`=0, `err`=0.
- Full write: write 0xDEADBEEF to entry 3 with mask 0xFFFFFFFF.
  - Next cycle: `done`=1 and `out0`=0xDEADBEEF at `read_addr0`=3.
  - Following idle cycle: `done`=0.
- Masked write: entry 3 = 0xDEADBEEF, write `in`=0x12345678 with mask 0x0000FFFF → entry 3 = 0xDEAD5678. A second write with mask 0 → `done`=1, value unchanged.
- Bypass vs. no bypass: same-cycle write of 0xA5A5A5A5 to entry 5 while `read_addr1`=5.
  - `BYPASS`=1: `out1`=0xA5A5A5A5 in the same cycle.
  - `BYPASS`=0: `out1` shows the old value, then 0xA5A5A5A5 after the edge.
- Out of range (`NUM_REGS`=6, `ADDR_W`=3): write to address 7 → next cycle `err`=1, `done`=0, entries 0–5 unchanged. A read of address 6 → 0.
- Async reset mid-stream: back-to-back writes to entries 0,1,2 with reset pulsed between edges → all entries and `done` go to 0 immediately (before the next edge), and the write to entry 2 is discarded.
